// File: rtl/ctrl_rega_fsm.sv
// Irrigation sequencer: decides when to water, presets and gates the 5-to-0
// countdown counter, and reads its value back to end each watering pass.
module ctrl_rega_fsm #(
  parameter int SOAK_TICKS = 3,
  parameter int CICLOS_W   = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Tick,
  input  logic [1:0]          Umidade,
  input  logic                NivelBaixo,
  input  logic [2:0]          Count,
  output logic                LoadCnt,
  output logic                CntEn,
  output logic                Valvula,
  output logic                Alarme,
  output logic [CICLOS_W-1:0] Ciclos
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WATER,
    S_SOAK,
    S_ALARM
  } state_t;

  localparam logic [3:0]          SOAK_INIT  = 4'(SOAK_TICKS);
  localparam logic [CICLOS_W-1:0] CICLOS_MAX = {CICLOS_W{1'b1}};

  state_t              state_q, state_d;
  logic [1:0]          pass_q, pass_d;
  logic [3:0]          soak_q, soak_d;
  logic [CICLOS_W-1:0] ciclos_q, ciclos_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pass_q   <= '0;
      soak_q   <= '0;
      ciclos_q <= '0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      soak_q   <= soak_d;
      ciclos_q <= ciclos_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    soak_d   = soak_q;
    ciclos_d = ciclos_q;
    case (state_q)
      S_IDLE: begin
        if (Tick) begin
          if (NivelBaixo) begin
            state_d = S_ALARM;
          end else if (Umidade[1]) begin
            state_d = S_LOAD;
            pass_d  = (Umidade == 2'b11) ? 2'd2 : 2'd1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_WATER;
      end
      S_WATER: begin
        // Tank-low and counter-fault aborts outrank the end-of-pass tick.
        if (NivelBaixo) begin
          state_d = S_ALARM;
        end else if (Count[2] && Count[1]) begin
          state_d = S_ALARM;
        end else if (Tick && (Count == 3'd0)) begin
          pass_d = pass_q - 2'd1;
          if (pass_q > 2'd1) begin
            state_d = S_SOAK;
            soak_d  = SOAK_INIT;
          end else begin
            state_d = S_IDLE;
            if (ciclos_q != CICLOS_MAX) begin
              ciclos_d = ciclos_q + 1'b1;
            end
          end
        end
      end
      S_SOAK: begin
        if (NivelBaixo) begin
          state_d = S_ALARM;
        end else if (Tick) begin
          soak_d = soak_q - 4'd1;
          if (soak_q == 4'd1) begin
            state_d = S_LOAD;
          end
        end
      end
      S_ALARM: begin
        if (Tick && !NivelBaixo) begin
          state_d = S_IDLE;
          pass_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    LoadCnt = 1'b0;
    CntEn   = 1'b0;
    Valvula = 1'b0;
    Alarme  = 1'b0;
    case (state_q)
      S_LOAD:  LoadCnt = 1'b1;
      S_WATER: begin
        CntEn   = 1'b1;
        Valvula = 1'b1;
      end
      S_ALARM: Alarme = 1'b1;
      default: ;
    endcase
  end

  assign Ciclos = ciclos_q;

endmodule

// File: tb/tb_ctrl_rega_fsm.sv
// Bench for ctrl_rega_fsm: external 5-to-0 counter model, tick-counting
// behavioural reference checked every cycle, plus directed literal checks.
module tb_ctrl_rega_fsm;

  localparam int SOAK = 3;
  localparam int CW   = 4;

  logic          Clk = 1'b0;
  logic          Reset, Tick, NivelBaixo;
  logic [1:0]    Umidade;
  logic [2:0]    Count;
  logic          LoadCnt, CntEn, Valvula, Alarme;
  logic [CW-1:0] Ciclos;

  ctrl_rega_fsm #(.SOAK_TICKS(SOAK), .CICLOS_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Umidade(Umidade),
    .NivelBaixo(NivelBaixo), .Count(Count), .LoadCnt(LoadCnt),
    .CntEn(CntEn), .Valvula(Valvula), .Alarme(Alarme), .Ciclos(Ciclos)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // External countdown counter: preset to 5, decrement on Tick while enabled, hold at 0.
  logic [2:0] cnt_q;
  logic       force_en;
  logic [2:0] force_val;
  assign Count = force_en ? force_val : cnt_q;

  always @(posedge Clk) begin
    if (Reset)                              cnt_q <= 3'd0;
    else if (LoadCnt)                       cnt_q <= 3'd5;
    else if (CntEn && Tick && cnt_q != 0)   cnt_q <= cnt_q - 3'd1;
  end

  int vt_cnt = 0;
  int ld_cnt = 0;
  always @(posedge Clk) begin
    if (Tick && Valvula) vt_cnt++;
    if (LoadCnt)         ld_cnt++;
  end

  // Reference: a pass is "valve open for six ticks"; soak is SOAK ticks closed.
  localparam int M_IDLE = 0, M_LOAD = 1, M_WATER = 2, M_SOAK = 3, M_ALARM = 4;
  int m_mode = M_IDLE;
  int m_wticks = 0;
  int m_passes = 0;
  int m_soak = 0;
  int m_ciclos = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode = M_IDLE; m_wticks = 0; m_passes = 0; m_soak = 0; m_ciclos = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (Tick) begin
          if (NivelBaixo) m_mode = M_ALARM;
          else if (Umidade >= 2) begin
            m_mode = M_LOAD;
            m_passes = (Umidade == 3) ? 2 : 1;
          end
        end
        M_LOAD: begin
          m_mode = M_WATER;
          m_wticks = 0;
        end
        M_WATER: begin
          if (NivelBaixo || Count >= 6) m_mode = M_ALARM;
          else if (Tick) begin
            if (m_wticks == 5) begin
              m_passes = m_passes - 1;
              if (m_passes > 0) begin
                m_mode = M_SOAK;
                m_soak = SOAK;
              end else begin
                m_mode = M_IDLE;
                if (m_ciclos < (1 << CW) - 1) m_ciclos = m_ciclos + 1;
              end
            end else begin
              m_wticks = m_wticks + 1;
            end
          end
        end
        M_SOAK: begin
          if (NivelBaixo) m_mode = M_ALARM;
          else if (Tick) begin
            m_soak = m_soak - 1;
            if (m_soak == 0) m_mode = M_LOAD;
          end
        end
        default: if (Tick && !NivelBaixo) begin
          m_mode = M_IDLE;
          m_passes = 0;
        end
      endcase
    end
  end

  bit chk_en = 1'b0;
  always @(negedge Clk) begin
    if (chk_en) begin
      check("cyc_loadcnt", int'(LoadCnt), int'(m_mode == M_LOAD));
      check("cyc_cnten",   int'(CntEn),   int'(m_mode == M_WATER));
      check("cyc_valvula", int'(Valvula), int'(m_mode == M_WATER));
      check("cyc_alarme",  int'(Alarme),  int'(m_mode == M_ALARM));
      check("cyc_ciclos",  int'(Ciclos),  m_ciclos);
    end
  end

  task automatic cyc(input bit t);
    @(negedge Clk);
    Tick = t;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    end
  endtask

  // Tick every 4th cycle until the valve is open with the counter at v (bounded).
  task automatic run_until_count(input int v, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (Valvula && Count == 3'(v)) begin
        hit = 1'b1;
        break;
      end
      Tick = (i % 4 == 0);
    end
    Tick = 1'b0;
    check(nm, int'(hit), 1);
  endtask

  initial begin
    Reset = 1'b1; Tick = 1'b0; NivelBaixo = 1'b0; Umidade = 2'b00;
    force_en = 1'b0; force_val = 3'd0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk_en = 1'b1;
    check("rst_outputs", int'({LoadCnt, CntEn, Valvula, Alarme}), 0);
    check("rst_ciclos", int'(Ciclos), 0);

    // Soaked soil: nothing happens
    ticks(4);
    check("soaked_idle", int'({LoadCnt, CntEn, Valvula, Alarme}), 0);

    // Tank low while idle
    NivelBaixo = 1'b1;
    ticks(1);
    check("idle_low_alarm", int'(Alarme), 1);
    NivelBaixo = 1'b0;
    ticks(1);
    check("alarm_clear", int'(Alarme), 0);

    // Dry: one pass
    vt_cnt = 0; ld_cnt = 0;
    Umidade = 2'b10;
    ticks(1);
    Umidade = 2'b00;
    ticks(8);
    check("dry_valve_ticks", vt_cnt, 6);
    check("dry_loads", ld_cnt, 1);
    check("dry_ciclos", int'(Ciclos), 1);
    check("dry_valve_off", int'(Valvula), 0);

    // Very dry: two passes with soak between
    vt_cnt = 0; ld_cnt = 0;
    Umidade = 2'b11;
    ticks(1);
    Umidade = 2'b00;
    ticks(18);
    check("vdry_valve_ticks", vt_cnt, 12);
    check("vdry_loads", ld_cnt, 2);
    check("vdry_ciclos", int'(Ciclos), 2);

    // Tank low mid-pass without a tick
    Umidade = 2'b10;
    run_until_count(3, "wait_count3");
    Umidade = 2'b00;
    NivelBaixo = 1'b1;
    @(negedge Clk);
    check("low_valve_off", int'(Valvula), 0);
    check("low_alarm_on", int'(Alarme), 1);
    ticks(2);
    check("low_alarm_hold", int'(Alarme), 1);
    NivelBaixo = 1'b0;
    ticks(1);
    check("low_back_idle", int'(Alarme), 0);
    check("low_ciclos_kept", int'(Ciclos), 2);

    // Counter fault
    Umidade = 2'b10;
    run_until_count(5, "wait_count5");
    Umidade = 2'b00;
    force_en = 1'b1; force_val = 3'd7;
    @(negedge Clk);
    check("fault_alarm", int'(Alarme), 1);
    check("fault_valve_off", int'(Valvula), 0);
    force_en = 1'b0;
    ticks(2);
    check("fault_ciclos_kept", int'(Ciclos), 2);

    // Reset mid-pass
    Umidade = 2'b10;
    run_until_count(2, "wait_count2");
    Umidade = 2'b00;
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid_valve", int'(Valvula), 0);
    check("rst_mid_ciclos", int'(Ciclos), 0);
    Reset = 1'b0;

    // Back-to-back dry cycles saturate the tally
    Umidade = 2'b10;
    ticks(145);
    Umidade = 2'b00;
    ticks(8);
    check("sat_ciclos", int'(Ciclos), 15);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctrl_rega_fsm.md
Name: ctrl_rega_fsm

Overview:
- Irrigation sequencer directly downstream of the 5-to-0 countdown counter.
- Decides when to water from soil-moisture and tank-level inputs.
- Loads the counter (drives its Pos0 preset) and gates its clock, then reads its Q2..Q0 value to end each watering pass.
- Drives the valve, the tank alarm and a completed-cycle tally.

Parameters:
- SOAK_TICKS, 3, number of Tick pulses the valve stays closed between two passes (range 1..15).
- CICLOS_W, 4, width of the completed-cycle counter.

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Tick  input  1  one-Clk-wide timebase pulse from the prescaler.
- Umidade  input  2  soil moisture: 00 soaked, 01 moist, 10 dry, 11 very dry.
- NivelBaixo  input  1  tank-low sensor, 1 = insufficient water.
- Count  input  3  countdown value (Q2..Q0 of the 5-to-0 counter).
- LoadCnt  output  1  one-cycle preset pulse to counter Pos0 (counter loads 5).
- CntEn  output  1  counter clock enable; counter decrements on Tick while high.
- Valvula  output  1  valve open.
- Alarme  output  1  tank-low / fault alarm.
- Ciclos  output  CICLOS_W  completed watering cycles, saturating.

Behaviour:
- Clocking and reset:
  - Reset sampled on the Clk edge.
  - Reset forces state IDLE, LoadCnt=0, CntEn=0, Valvula=0, Alarme=0, Ciclos=0, pass counter=0, soak counter=0.
  - Reset has priority over every other event, including mid-WATER: the valve closes on the same edge.
- Outputs are Moore-decoded from the state register only; no input-to-output combinational path.
- States: IDLE, LOAD, WATER, SOAK, ALARM.
- IDLE (all outputs 0):
  - Tick & NivelBaixo -> ALARM.
  - Tick & !NivelBaixo & Umidade>=2 -> LOAD; pass counter = 2 if Umidade==3, else 1.
  - Otherwise stay in IDLE.
  - Umidade is sampled only on Tick.
- LOAD:
  - LoadCnt=1 for exactly one Clk.
  - Unconditionally -> WATER next cycle, even if Tick is high.
- WATER (Valvula=1, CntEn=1). Evaluated every Clk, in this priority:
  1. NivelBaixo=1 (any cycle, Tick not required) -> ALARM; cycle not counted.
  2. Count in {6,7} -> ALARM (counter fault).
  3. Tick & Count==0 -> decrement pass counter. If passes remain -> SOAK and load soak counter with SOAK_TICKS. Otherwise -> IDLE and Ciclos+1, saturating at 2^CICLOS_W-1.
  4. Otherwise stay in WATER.
  - The counter holds at 0, so a single pass lasts 6 Ticks after LOAD: 5 decrements plus the terminal Tick.
- SOAK (all outputs 0):
  - Decrement the soak counter on each Tick.
  - On the Tick that brings it to 0 -> LOAD.
  - NivelBaixo=1 -> ALARM, which takes priority.
- ALARM (Alarme=1, Valvula=0, CntEn=0):
  - Tick & !NivelBaixo -> IDLE; pass counter cleared.
  - Otherwise stay in ALARM.
- Simultaneous events:
  - NivelBaixo together with a terminal Tick in WATER -> ALARM; Ciclos unchanged.
  - Umidade changing mid-cycle has no effect until the next IDLE decision.
- Ciclos changes only on a WATER->IDLE transition.

Test Plan:
- Reset=1 for 2 cycles, then Tick pulses with Umidade=00 -> stays IDLE; every output 0, Ciclos=0.
- Umidade=10, NivelBaixo=0, bench counter model loads 5 -> exactly one LoadCnt pulse, then Valvula=1 for 6 Ticks, then IDLE with Ciclos=1 and Valvula=0.
- Umidade=11, SOAK_TICKS=3 -> Valvula high for 6 Ticks, low for 3 Ticks, a second LoadCnt pulse, high for 6 more Ticks, then Ciclos=1.
- NivelBaixo raised at Count=3 in WATER, no Tick -> next edge Valvula=0, Alarme=1. Hold until NivelBaixo=0 plus a Tick -> IDLE, Ciclos unchanged.
- Force Count=7 in WATER -> ALARM next edge.
- Reset asserted at Count=2 in WATER -> Valvula=0 at that edge.
- 20 back-to-back dry cycles with CICLOS_W=4 -> Ciclos saturates at 15.
